pdm_cic_decimator: RTL and testbench
====================================

# pdm_cic_decimator

Parametrised PDM microphone front end: generates the microphone bit clock, samples 1-bit PDM data on each rising mic-clock edge, and decimates it through an ORDER-stage CIC filter to signed OUT_WIDTH-bit PCM. It replaces the fixed 256-tick tally and the fixed chain of 16-tap decimators with one block that is configurable in clock ratio, filter order, decimation rate and output width. It also adds saturation and a run/clear enable. It sits between the mic pins and the downstream FIR/pitch pipeline.

## Interface
- CLK_DIV, 32: system clocks per mic-clock period; even, ≥ 2·(ORDER+3)
- ORDER, 4: CIC integrator/comb stages, 1..5
- DEC_RATE, 64: PDM ticks per output sample; power of two, ≥ 2
- OUT_WIDTH, 16: output sample width; ≤ ORDER·log2(DEC_RATE)+1
- clk_in  input  1  system clock (100 MHz)
- rst_in  input  1  reset; asynchronous, active-high
- enable_in  input  1  run when high; when low, acts as a synchronous clear of the counters and datapath
- mic_data_in  input  1  PDM bit from the microphone
- mic_clk_out  output  1  microphone clock; high while the divider count < CLK_DIV/2
- pdm_valid_out  output  1  single-cycle pulse on each mic-clock rising edge (tick)
- audio_out  output  signed OUT_WIDTH  latest PCM sample, held between updates
- audio_valid_out  output  1  single-cycle pulse when audio_out updates

## Operation
- Reset, or enable_in low: all outputs 0; divider, tick counter, integrators and comb delays cleared; FSM set to IDLE.
- Divider: counts 0..CLK_DIV-1, then wraps. mic_clk_out is registered from (count < CLK_DIV/2). A tick is the cycle mic_clk_out = 1 while its previous value = 0.
- On a tick:
  - x = +1 if mic_data_in = 1, else −1.
  - Integrators are pipelined and all update on the same edge: I1 ← I1+x, Ik ← Ik+I(k−1) using old values.
  - Width W = ORDER·log2(DEC_RATE)+2. Arithmetic is two's-complement and wraps; wrap is intended.
- Tick counter counts 0..DEC_RATE−1. The tick on which it equals DEC_RATE−1 is the decimating tick; on the following cycle I_ORDER is captured into v.
- FSM states:
  - IDLE: waiting for a capture.
  - COMB: runs ORDER cycles; in cycle k: v ← v − Dk and Dk ← v (old v).
  - OUT: one cycle; y = v >>> SHIFT, where SHIFT = ORDER·log2(DEC_RATE)+1−OUT_WIDTH. y is saturated to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1], registered to audio_out, and audio_valid_out pulses. The FSM then returns to IDLE.
- Full-scale ones yields v = +2^(W−2), which saturates to the max positive value. All zeros yields the exact minimum.
- The first ORDER output samples after a clear are transient; later samples are settled.

## Timing
- mic_clk_out period = CLK_DIV cycles with 50 % duty. pdm_valid_out is exactly one cycle per period.
- audio_valid_out is high exactly ORDER+2 cycles after the decimating tick cycle. One output every DEC_RATE·CLK_DIV cycles.
- CLK_DIV ≥ 2·(ORDER+3) guarantees the FSM is back in IDLE before the next tick; a capture never overlaps a busy FSM.
- rst_in asserted mid-COMB: the pending output is discarded and audio_valid_out does not pulse.
- enable_in falling during COMB: same as reset, but synchronous.
- enable_in rising: the first tick occurs CLK_DIV/2+1 cycles later at most.
- mic_data_in is sampled only in the tick cycle; values at other times are ignored.

## Structure
- Package pdm_pkg:
  - cic_state_t enum (IDLE, COMB, OUT)
  - function cic_width(order, rate) returning W
  - function cic_shift(order, rate, out_w) returning SHIFT
  - parameter-legality checks as elaboration assertions
- Sub-module cic_comb_seq: holds the sequential comb chain (delay registers, FSM, shift and saturate). The top level keeps the divider, tick logic and integrators.

## Test plan
- Default parameters, reset released: mic_clk_out period 32 cycles, high for 16; pdm_valid_out one cycle per period; audio_out = 0 until the first audio_valid_out.
- mic_data_in held at 1: audio_valid_out every 2048 cycles; the 5th and later outputs equal 32767 (saturated).
- mic_data_in held at 0: the 5th and later outputs equal −32768.
- Alternating bit per tick (…1010…): settled outputs equal 0. Also check audio_valid_out occurs exactly 6 cycles after the decimating tick.
- Faults mid-operation:
  - rst_in pulsed during COMB: no valid pulse and all state zeroed.
  - enable_in low for 100 cycles: mic_clk_out held 0, no ticks; after re-enable, the output sequence restarts from transient.
- Parameter sweep (ORDER=2, DEC_RATE=16, OUT_WIDTH=8, CLK_DIV=12): ones gives 127, zeros gives −128, valid latency = 4 cycles.

Source files
------------

// File: rtl/pdm_pkg.sv
// pdm_pkg: shared FSM type and sizing helpers for the PDM CIC decimator.
// Integrator width is ORDER*log2(DEC_RATE)+2 so full-scale input never wraps the comb output.
package pdm_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COMB,
      OUT
   } cic_state_t;

   function automatic int cic_width(input int order, input int rate);
      return order * $clog2(rate) + 2;
   endfunction

   function automatic int cic_shift(input int order, input int rate,
                                    input int out_w);
      return order * $clog2(rate) + 1 - out_w;
   endfunction

   function automatic bit cic_params_ok(input int clk_div, input int order,
                                        input int rate, input int out_w);
      bit ok;
      ok = 1'b1;
      if (clk_div % 2 != 0) ok = 1'b0;
      if (clk_div < 2 * (order + 3)) ok = 1'b0;
      if (order < 1 || order > 5) ok = 1'b0;
      if (rate < 2 || (rate & (rate - 1)) != 0) ok = 1'b0;
      if (out_w < 1 || out_w > order * $clog2(rate) + 1) ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/cic_comb_seq.sv
// cic_comb_seq: time-multiplexed CIC comb chain followed by shift and saturation.
// One comb stage per cycle: ORDER cycles in COMB, then a single OUT cycle.
module cic_comb_seq
   import pdm_pkg::*;
#(
   parameter int ORDER     = 4,
   parameter int DEC_RATE  = 64,
   parameter int OUT_WIDTH = 16,
   parameter int W         = cic_width(ORDER, DEC_RATE)
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_clr,
   input  logic                        i_cap,
   input  logic signed [W-1:0]         i_v,
   output logic signed [OUT_WIDTH-1:0] o_audio,
   output logic                        o_valid
);

   localparam int SHIFT = cic_shift(ORDER, DEC_RATE, OUT_WIDTH);
   localparam int KW    = (ORDER > 1) ? $clog2(ORDER) : 1;
   localparam int PAD   = W - OUT_WIDTH + 1;

   localparam logic signed [W-1:0] Y_MAX =
      {{PAD{1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [W-1:0] Y_MIN =
      {{PAD{1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   cic_state_t                 r_state;
   cic_state_t                 w_state_nx;
   logic [KW-1:0]              r_k;
   logic signed [W-1:0]        r_v;
   logic signed [W-1:0]        r_dly [ORDER];
   logic signed [W-1:0]        w_y;
   logic signed [OUT_WIDTH-1:0] w_sat;
   logic                       w_last;

   assign w_last = (r_k == KW'(ORDER - 1));
   assign w_y    = r_v >>> SHIFT;

   always_comb begin
      w_sat = w_y[OUT_WIDTH-1:0];
      if (w_y > Y_MAX) begin
         w_sat = Y_MAX[OUT_WIDTH-1:0];
      end else if (w_y < Y_MIN) begin
         w_sat = Y_MIN[OUT_WIDTH-1:0];
      end
   end

   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         IDLE:    if (i_cap) w_state_nx = COMB;
         COMB:    if (w_last) w_state_nx = OUT;
         OUT:     w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else if (i_clr) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Comb stage k: v <= v - Dk while Dk takes the old v.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_k     <= '0;
         r_v     <= '0;
         o_audio <= '0;
         o_valid <= 1'b0;
         for (int k = 0; k < ORDER; k++) r_dly[k] <= '0;
      end else if (i_clr) begin
         r_k     <= '0;
         r_v     <= '0;
         o_audio <= '0;
         o_valid <= 1'b0;
         for (int k = 0; k < ORDER; k++) r_dly[k] <= '0;
      end else begin
         o_valid <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (i_cap) begin
                  r_v <= i_v;
                  r_k <= '0;
               end
            end
            COMB: begin
               r_v        <= r_v - r_dly[r_k];
               r_dly[r_k] <= r_v;
               r_k        <= r_k + 1'b1;
            end
            OUT: begin
               o_audio <= w_sat;
               o_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: mic clock divider, tick sampler and pipelined CIC integrators.
// The decimated value is handed to cic_comb_seq for the comb chain and output stage.
module pdm_cic_decimator
   import pdm_pkg::*;
#(
   parameter int CLK_DIV   = 32,
   parameter int ORDER     = 4,
   parameter int DEC_RATE  = 64,
   parameter int OUT_WIDTH = 16
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic                        enable_in,
   input  logic                        mic_data_in,
   output logic                        mic_clk_out,
   output logic                        pdm_valid_out,
   output logic signed [OUT_WIDTH-1:0] audio_out,
   output logic                        audio_valid_out
);

   localparam int W    = cic_width(ORDER, DEC_RATE);
   localparam int DW   = $clog2(CLK_DIV);
   localparam int TW   = $clog2(DEC_RATE);
   localparam int HALF = CLK_DIV / 2;

   if (!cic_params_ok(CLK_DIV, ORDER, DEC_RATE, OUT_WIDTH)) begin : g_bad_params
      $error("pdm_cic_decimator: illegal parameter combination");
   end

   logic [DW-1:0]       r_div;
   logic                r_mclk;
   logic                r_mclk_d;
   logic [TW-1:0]       r_tcnt;
   logic signed [W-1:0] r_int [ORDER];
   logic signed [W-1:0] w_int_nx [ORDER];
   logic signed [W-1:0] w_x;
   logic                w_tick;
   logic                w_dec;

   assign w_tick        = r_mclk & ~r_mclk_d;
   assign w_dec         = w_tick & (r_tcnt == TW'(DEC_RATE - 1));
   assign w_x           = {{(W-1){~mic_data_in}}, 1'b1};
   assign mic_clk_out   = r_mclk;
   assign pdm_valid_out = w_tick;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_div    <= '0;
         r_mclk   <= 1'b0;
         r_mclk_d <= 1'b0;
      end else if (!enable_in) begin
         r_div    <= '0;
         r_mclk   <= 1'b0;
         r_mclk_d <= 1'b0;
      end else begin
         r_div    <= (r_div == DW'(CLK_DIV - 1)) ? '0 : r_div + 1'b1;
         r_mclk   <= (r_div < DW'(HALF));
         r_mclk_d <= r_mclk;
      end
   end

   // Integrators are pipelined: each stage sums the previous stage's old value.
   always_comb begin
      w_int_nx[0] = r_int[0] + w_x;
      for (int k = 1; k < ORDER; k++) begin
         w_int_nx[k] = r_int[k] + r_int[k-1];
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_tcnt <= '0;
         for (int k = 0; k < ORDER; k++) r_int[k] <= '0;
      end else if (!enable_in) begin
         r_tcnt <= '0;
         for (int k = 0; k < ORDER; k++) r_int[k] <= '0;
      end else if (w_tick) begin
         r_tcnt <= r_tcnt + 1'b1;
         for (int k = 0; k < ORDER; k++) r_int[k] <= w_int_nx[k];
      end
   end

   // The comb takes the post-update last integrator so v holds it on the next cycle.
   cic_comb_seq #(
      .ORDER     (ORDER),
      .DEC_RATE  (DEC_RATE),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_comb (
      .i_clk   (clk_in),
      .i_rst   (rst_in),
      .i_clr   (~enable_in),
      .i_cap   (w_dec),
      .i_v     (w_int_nx[ORDER-1]),
      .o_audio (audio_out),
      .o_valid (audio_valid_out)
   );

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb_pdm_cic_decimator: randomized checks of the PDM CIC decimator against a
// reference built from integrator sums and a binomial comb formula.
module tb_pdm_cic_decimator;

   localparam int CD_A = 32, OR_A = 4, DR_A = 64, OW_A = 16, LG_A = 6;
   localparam int CD_B = 12, OR_B = 2, DR_B = 16, OW_B = 8,  LG_B = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, en_a, en_b, d_a, d_b;
   logic mclk_a, pv_a, av_a, mclk_b, pv_b, av_b;
   logic signed [OW_A-1:0] au_a;
   logic signed [OW_B-1:0] au_b;

   pdm_cic_decimator #(
      .CLK_DIV(CD_A), .ORDER(OR_A), .DEC_RATE(DR_A), .OUT_WIDTH(OW_A)
   ) dut_a (
      .clk_in(clk), .rst_in(rst), .enable_in(en_a), .mic_data_in(d_a),
      .mic_clk_out(mclk_a), .pdm_valid_out(pv_a),
      .audio_out(au_a), .audio_valid_out(av_a)
   );

   pdm_cic_decimator #(
      .CLK_DIV(CD_B), .ORDER(OR_B), .DEC_RATE(DR_B), .OUT_WIDTH(OW_B)
   ) dut_b (
      .clk_in(clk), .rst_in(rst), .enable_in(en_b), .mic_data_in(d_b),
      .mic_clk_out(mclk_b), .pdm_valid_out(pv_b),
      .audio_out(au_b), .audio_valid_out(av_b)
   );

   bit sel_b = 1'b0;
   logic obs_mclk, obs_pv, obs_av;
   longint obs_au;
   assign obs_mclk = sel_b ? mclk_b : mclk_a;
   assign obs_pv   = sel_b ? pv_b : pv_a;
   assign obs_av   = sel_b ? av_b : av_a;
   assign obs_au   = sel_b ? longint'(au_b) : longint'(au_a);

   int errs = 0;
   int checks = 0;

   // Reference state: cycles since clear, integrator values, captured v history.
   int m_cd, m_ord, m_rate, m_ow, m_sh;
   longint m_c, m_due, m_dec, m_pend;
   longint integ [6];
   int m_ticks;
   longint vh [$];
   bit exp_mclk, exp_pv, exp_av;
   longint exp_au;

   task automatic cfg(input bit b);
      sel_b  = b;
      m_cd   = b ? CD_B : CD_A;
      m_ord  = b ? OR_B : OR_A;
      m_rate = b ? DR_B : DR_A;
      m_ow   = b ? OW_B : OW_A;
      m_sh   = m_ord * (b ? LG_B : LG_A) + 1 - m_ow;
   endtask

   task automatic model_clear();
      m_c = 0; m_due = -1; m_dec = -1; m_pend = 0; m_ticks = 0;
      for (int k = 0; k < 6; k++) integ[k] = 0;
      vh.delete();
      exp_mclk = 0; exp_pv = 0; exp_av = 0; exp_au = 0;
   endtask

   function automatic bit is_tick();
      return m_c >= 1 && ((m_c - 1) % m_cd) == 0;
   endfunction

   function automatic longint binom(input int n, input int k);
      longint r = 1;
      for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
      return r;
   endfunction

   // Nth-order comb of the captured sequence (zero before the clear), then shift/saturate.
   function automatic longint expected_pcm();
      longint s, y, lim;
      int m;
      s = 0;
      m = vh.size() - 1;
      for (int k = 0; k <= m_ord; k++) begin
         if (m - k >= 0) s += ((k % 2) ? -binom(m_ord, k) : binom(m_ord, k)) * vh[m-k];
      end
      y = s >>> m_sh;
      lim = longint'(1) << (m_ow - 1);
      if (y > lim - 1) y = lim - 1;
      if (y < -lim) y = -lim;
      return y;
   endfunction

   task automatic model_edge(input bit d);
      longint nx [6];
      if (is_tick()) begin
         nx = integ;
         nx[0] = integ[0] + (d ? 1 : -1);
         for (int k = 1; k < m_ord; k++) nx[k] = integ[k] + integ[k-1];
         integ = nx;
         if (m_ticks % m_rate == m_rate - 1) begin
            vh.push_back(integ[m_ord-1]);
            m_dec  = m_c;
            m_due  = m_c + m_ord + 2;
            m_pend = expected_pcm();
         end
         m_ticks++;
      end
      m_c++;
      exp_mclk = ((m_c - 1) % m_cd) < m_cd / 2;
      exp_pv   = ((m_c - 1) % m_cd) == 0;
      exp_av   = (m_c == m_due);
      if (exp_av) exp_au = m_pend;
   endtask

   task automatic step(input bit d);
      if (sel_b) d_b = d; else d_a = d;
      model_edge(d);
      @(posedge clk);
      #1;
   endtask

   task automatic restart();
      if (sel_b) en_b = 1'b0; else en_a = 1'b0;
      @(posedge clk);
      #1;
      if (sel_b) en_b = 1'b1; else en_a = 1'b1;
      model_clear();
   endtask

   task automatic test_reset();
      int nhigh, npv;
      cfg(1'b0);
      rst = 1'b1; en_a = 1'b1; en_b = 1'b0; d_a = 1'b0; d_b = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (mclk_a !== 1'b0) begin errs++; $display("FAIL rst_mclk: got %0b want 0", mclk_a); end
      checks++; if (pv_a !== 1'b0) begin errs++; $display("FAIL rst_pv: got %0b want 0", pv_a); end
      checks++; if (av_a !== 1'b0) begin errs++; $display("FAIL rst_av: got %0b want 0", av_a); end
      checks++; if (au_a !== '0) begin errs++; $display("FAIL rst_au: got %0d want 0", au_a); end
      rst = 1'b0;
      model_clear();
      nhigh = 0; npv = 0;
      for (int i = 0; i < 3 * CD_A; i++) begin
         step(1'($urandom));
         nhigh += int'(obs_mclk); npv += int'(obs_pv);
         checks++; if (obs_mclk !== exp_mclk) begin errs++; $display("FAIL mclk: cycle %0d got %0b want %0b", m_c, obs_mclk, exp_mclk); end
         checks++; if (obs_pv !== exp_pv) begin errs++; $display("FAIL pdm_valid: cycle %0d got %0b want %0b", m_c, obs_pv, exp_pv); end
         checks++; if (obs_au !== 0 || obs_av !== 1'b0) begin errs++; $display("FAIL early_audio: cycle %0d got %0d/%0b want 0/0", m_c, obs_au, obs_av); end
      end
      checks++; if (nhigh !== 3 * CD_A / 2) begin errs++; $display("FAIL mclk_duty: got %0d want %0d", nhigh, 3 * CD_A / 2); end
      checks++; if (npv !== 3) begin errs++; $display("FAIL pv_count: got %0d want 3", npv); end
   endtask

   task automatic test_level(input bit lvl, input int nmax, input longint sat);
      int nout;
      longint lastc;
      cfg(1'b0);
      restart();
      nout = 0; lastc = -1;
      while (nout < nmax) begin
         step(lvl);
         checks++; if (obs_av !== exp_av) begin errs++; $display("FAIL level%0b_valid: cycle %0d got %0b want %0b", lvl, m_c, obs_av, exp_av); end
         if (obs_av === 1'b1) begin
            if (lastc >= 0) begin
               checks++; if (m_c - lastc !== 2048) begin errs++; $display("FAIL level%0b_period: got %0d want 2048", lvl, m_c - lastc); end
            end
            lastc = m_c;
         end
         if (exp_av) begin
            nout++;
            checks++; if (obs_au !== exp_au) begin errs++; $display("FAIL level%0b_model: out %0d got %0d want %0d", lvl, nout, obs_au, exp_au); end
            if (nout >= OR_A + 1) begin
               checks++; if (obs_au !== sat) begin errs++; $display("FAIL level%0b_sat: out %0d got %0d want %0d", lvl, nout, obs_au, sat); end
            end
         end
      end
   endtask

   task automatic test_alternating();
      int nout;
      bit d;
      cfg(1'b0);
      restart();
      nout = 0;
      while (nout < 6) begin
         d = is_tick() ? (m_ticks % 2 == 0) : 1'($urandom);
         step(d);
         checks++; if (obs_av !== exp_av) begin errs++; $display("FAIL alt_valid: cycle %0d got %0b want %0b", m_c, obs_av, exp_av); end
         if (obs_av === 1'b1) begin
            checks++; if (m_c - m_dec !== OR_A + 2) begin errs++; $display("FAIL alt_latency: got %0d want %0d", m_c - m_dec, OR_A + 2); end
         end
         if (exp_av) begin
            nout++;
            checks++; if (obs_au !== exp_au) begin errs++; $display("FAIL alt_model: out %0d got %0d want %0d", nout, obs_au, exp_au); end
            if (nout >= OR_A + 1) begin
               checks++; if (obs_au !== 0) begin errs++; $display("FAIL alt_zero: out %0d got %0d want 0", nout, obs_au); end
            end
         end
      end
   endtask

   task automatic test_random();
      int nout;
      cfg(1'b0);
      restart();
      nout = 0;
      while (nout < 3) begin
         step(1'($urandom));
         checks++; if (obs_av !== exp_av) begin errs++; $display("FAIL rand_valid: cycle %0d got %0b want %0b", m_c, obs_av, exp_av); end
         if (exp_av) begin
            nout++;
            checks++; if (obs_au !== exp_au) begin errs++; $display("FAIL rand_model: out %0d got %0d want %0d", nout, obs_au, exp_au); end
         end
      end
   endtask

   task automatic test_reset_mid_comb();
      int nout;
      cfg(1'b0);
      restart();
      nout = 0;
      while (!(nout >= 1 && m_due >= 0 && m_c == m_due - 4)) begin
         step(1'b1);
         if (exp_av) nout++;
      end
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         checks++; if (av_a !== 1'b0) begin errs++; $display("FAIL midrst_valid: got %0b want 0", av_a); end
         checks++; if (au_a !== '0 || mclk_a !== 1'b0) begin errs++; $display("FAIL midrst_zero: got %0d/%0b want 0/0", au_a, mclk_a); end
      end
      rst = 1'b0;
      model_clear();
      nout = 0;
      while (nout < 2) begin
         step(1'b1);
         checks++; if (obs_av !== exp_av) begin errs++; $display("FAIL postrst_valid: cycle %0d got %0b want %0b", m_c, obs_av, exp_av); end
         if (exp_av) begin
            nout++;
            checks++; if (obs_au !== exp_au) begin errs++; $display("FAIL postrst_model: out %0d got %0d want %0d", nout, obs_au, exp_au); end
         end
      end
   endtask

   task automatic test_enable_gap();
      int nout;
      cfg(1'b0);
      restart();
      nout = 0;
      while (nout < 1) begin
         step(1'b1);
         if (exp_av) nout++;
      end
      en_a = 1'b0;
      for (int i = 0; i < 100; i++) begin
         d_a = 1'($urandom);
         @(posedge clk);
         #1;
         checks++; if (mclk_a !== 1'b0 || pv_a !== 1'b0) begin errs++; $display("FAIL gap_clock: got %0b/%0b want 0/0", mclk_a, pv_a); end
         checks++; if (av_a !== 1'b0 || au_a !== '0) begin errs++; $display("FAIL gap_audio: got %0b/%0d want 0/0", av_a, au_a); end
      end
      en_a = 1'b1;
      model_clear();
      nout = 0;
      while (nout < 5) begin
         step(1'b1);
         checks++; if (obs_mclk !== exp_mclk) begin errs++; $display("FAIL reen_mclk: cycle %0d got %0b want %0b", m_c, obs_mclk, exp_mclk); end
         checks++; if (obs_av !== exp_av) begin errs++; $display("FAIL reen_valid: cycle %0d got %0b want %0b", m_c, obs_av, exp_av); end
         if (exp_av) begin
            nout++;
            checks++; if (obs_au !== exp_au) begin errs++; $display("FAIL reen_model: out %0d got %0d want %0d", nout, obs_au, exp_au); end
            if (nout == 1) begin
               checks++; if (obs_au >= 32767) begin errs++; $display("FAIL reen_transient: got %0d want below 32767", obs_au); end
            end
            if (nout == 5) begin
               checks++; if (obs_au !== 32767) begin errs++; $display("FAIL reen_settled: got %0d want 32767", obs_au); end
            end
         end
      end
   endtask

   task automatic test_sweep();
      int nout;
      bit d;
      en_a = 1'b0;
      cfg(1'b1);
      restart();
      for (int ph = 0; ph < 3; ph++) begin
         nout = 0;
         while (nout < 5) begin
            d = (ph == 0) ? 1'b1 : (ph == 1) ? 1'b0 : 1'($urandom);
            step(d);
            checks++; if (obs_av !== exp_av) begin errs++; $display("FAIL sweep_valid: phase %0d cycle %0d got %0b want %0b", ph, m_c, obs_av, exp_av); end
            if (obs_av === 1'b1) begin
               checks++; if (m_c - m_dec !== OR_B + 2) begin errs++; $display("FAIL sweep_latency: got %0d want %0d", m_c - m_dec, OR_B + 2); end
            end
            if (exp_av) begin
               nout++;
               checks++; if (obs_au !== exp_au) begin errs++; $display("FAIL sweep_model: phase %0d out %0d got %0d want %0d", ph, nout, obs_au, exp_au); end
               if (ph == 0 && nout >= OR_B + 1) begin
                  checks++; if (obs_au !== 127) begin errs++; $display("FAIL sweep_ones: got %0d want 127", obs_au); end
               end
               if (ph == 1 && nout >= OR_B + 2) begin
                  checks++; if (obs_au !== -128) begin errs++; $display("FAIL sweep_zeros: got %0d want -128", obs_au); end
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_level(1'b1, 6, 32767);
      test_level(1'b0, 6, -32768);
      test_alternating();
      test_random();
      test_reset_mid_comb();
      test_enable_gap();
      test_sweep();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
